mac_skew_feeder: RTL and testbench

//   Upstream feeder for the mac_cell systolic array. Accepts one N-lane vector per handshake
//   and skews it diagonally: lane i is delayed i advance cycles, so the operands meet in step
//   at every cell. Drives the array's shared shift_en/acc_en/acc_rst controls, flushes zeros

---
 rtl/mac_skew_feeder_pkg.sv | 20 ++
 rtl/mac_skew_feeder_if.sv | 28 ++
 rtl/mac_skew_feeder_skew_delay_line.sv | 30 +++
 rtl/mac_skew_feeder.sv | 86 ++++++++
 tb/tb_mac_skew_feeder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mac_skew_feeder_pkg.sv
// Shared types and helpers for the systolic-array skew feeder.
package mac_skew_feeder_pkg;

  localparam int N_DEF          = 4;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DONE
  } feeder_state_t;

  // Lane i of a packed vector sits at bits [i*width +: width].
  function automatic int laneLsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mac_skew_feeder_if.sv
// Producer-to-feeder vector stream: one N-lane vector per valid/ready handshake.
interface mac_skew_feeder_if
  import mac_skew_feeder_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] in_data;
  logic                    in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/mac_skew_feeder_skew_delay_line.sv
// One lane of the diagonal skew: a DEPTH-stage shift chain with advance enable and sync clear.
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout
);

  logic [DATA_WIDTH-1:0] r_stage [DEPTH];

  // Clear wins over advance so a tile always starts from an all-zero skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_din;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/mac_skew_feeder.sv
// Skews accepted N-lane vectors diagonally onto a systolic-array edge and sequences the
// array's shift/accumulate controls through clear, feed, zero-flush and done.
module mac_skew_feeder
  import mac_skew_feeder_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mac_skew_feeder_if.slave        s_in,
  output logic [N*DATA_WIDTH-1:0] o_out_data,
  output logic                    o_shift_en,
  output logic                    o_acc_en,
  output logic                    o_acc_rst,
  output logic                    o_busy,
  output logic                    o_done
);

  // N-1 cycles empty the skew, N-1 more carry the last operand to the far corner.
  localparam int FLUSH_CYCLES = 2 * (N - 1);
  localparam int CNT_W        = $clog2(2 * N);

  feeder_state_t    r_state;
  logic [CNT_W-1:0] r_flushCnt;
  logic             w_advance;
  logic             w_clear;

  assign w_advance = ((r_state == FEED) && s_in.in_valid) || (r_state == FLUSH);
  assign w_clear   = (r_state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_flushCnt <= '0;
    end else begin
      case (r_state)
        IDLE:  if (s_in.in_valid) r_state <= CLEAR;
        CLEAR: r_state <= FEED;
        FEED: begin
          if (s_in.in_valid && s_in.in_last) begin
            r_state    <= FLUSH;
            r_flushCnt <= '0;
          end
        end
        FLUSH: begin
          if (r_flushCnt == CNT_W'(FLUSH_CYCLES - 1)) r_state <= DONE;
          else                                         r_flushCnt <= r_flushCnt + 1'b1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_in.in_ready = (r_state == FEED);
  assign o_shift_en    = w_advance;
  assign o_acc_en      = w_advance;
  assign o_acc_rst     = w_clear;
  assign o_busy        = (r_state != IDLE);
  assign o_done        = (r_state == DONE);

  // Lane i gets i+1 registers; during FLUSH zeros are injected at every lane.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] w_laneIn;
    logic [DATA_WIDTH-1:0] w_laneOut;

    assign w_laneIn = (r_state == FEED) ? s_in.in_data[laneLsb(i, DATA_WIDTH) +: DATA_WIDTH]
                                        : '0;

    skew_delay_line #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_line (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_advance),
      .i_clr  (w_clear),
      .i_din  (w_laneIn),
      .o_dout (w_laneOut)
    );

    assign o_out_data[laneLsb(i, DATA_WIDTH) +: DATA_WIDTH] = w_laneOut;
  end

endmodule

// File: tb/tb_mac_skew_feeder.sv
// Scoreboard bench for mac_skew_feeder (N=4, DATA_WIDTH=8): a lane-history model predicts
// out_data per advance, per-cycle control expectations come from the bench's own phase plan.
module tb_mac_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int W  = N * DW;

  typedef enum {P_IDLE, P_CLEAR, P_FEED, P_BUBBLE, P_FLUSH, P_DONE} phase_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] o_out_data;
  logic         o_shift_en, o_acc_en, o_acc_rst, o_busy, o_done;

  mac_skew_feeder_if #(.N(N), .DATA_WIDTH(DW)) feedIf ();

  mac_skew_feeder #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_in       (feedIf),
    .o_out_data (o_out_data),
    .o_shift_en (o_shift_en),
    .o_acc_en   (o_acc_en),
    .o_acc_rst  (o_acc_rst),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  int           errCount   = 0;
  int           checkCount = 0;
  int           shiftCount = 0;
  logic [W-1:0] hist [N];
  logic [W-1:0] expOut;
  logic [W-1:0] sbQ [$];
  logic [W-1:0] advLog [$];
  bit           prevAdv;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic l);
    feedIf.in_valid = v;
    feedIf.in_data  = d;
    feedIf.in_last  = l;
  endtask

  function automatic logic [W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic resetModel();
    for (int j = 0; j < N; j++) hist[j] = '0;
    sbQ.delete();
    expOut  = '0;
    prevAdv = 1'b0;
  endtask

  // Lane i of out_data after an advance is lane i of the vector injected i advances earlier.
  function automatic logic [W-1:0] modelOut();
    logic [W-1:0] r;
    logic [W-1:0] h;
    r = '0;
    for (int i = 0; i < N; i++) begin
      h = hist[i];
      r[i*DW +: DW] = h[i*DW +: DW];
    end
    return r;
  endfunction

  // Entered #1 after a rising edge; drives, checks at the falling edge, returns #1 after the next rise.
  task automatic runCycle(input string tag, input phase_t ph, input logic v,
                          input logic [W-1:0] d, input logic l);
    bit eReady, adv;
    eReady = (ph == P_FEED) || (ph == P_BUBBLE);
    adv    = (ph == P_FEED) || (ph == P_FLUSH);
    applyStimulus(v, d, l);
    @(negedge clk);
    if (sbQ.size() > 0) expOut = sbQ.pop_front();
    if (prevAdv) advLog.push_back(o_out_data);
    checkOutput({tag, ".out"},    64'(o_out_data),     64'(expOut));
    checkOutput({tag, ".ready"},  64'(feedIf.in_ready), 64'(eReady));
    checkOutput({tag, ".shift"},  64'(o_shift_en),     64'(adv));
    checkOutput({tag, ".accEn"},  64'(o_acc_en),       64'(adv));
    checkOutput({tag, ".accRst"}, 64'(o_acc_rst),      64'(ph == P_CLEAR));
    checkOutput({tag, ".busy"},   64'(o_busy),         64'(ph != P_IDLE));
    checkOutput({tag, ".done"},   64'(o_done),         64'(ph == P_DONE));
    if (o_shift_en) shiftCount++;
    if (ph == P_CLEAR) begin
      for (int j = 0; j < N; j++) hist[j] = '0;
      sbQ.push_back('0);
    end
    if (adv) begin
      for (int j = N - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = (ph == P_FEED) ? d : '0;
      sbQ.push_back(modelOut());
    end
    prevAdv = adv;
    @(posedge clk);
    #1;
  endtask

  task automatic runTile(input string tag, input logic [W-1:0] vecs[$], input int bubbleAfter,
                         input int bubbles, input bit holdValid);
    int K;
    K = vecs.size();
    shiftCount = 0;
    advLog.delete();
    runCycle({tag, ".idle"},  P_IDLE,  1'b1, vecs[0], 1'b0);
    runCycle({tag, ".clear"}, P_CLEAR, 1'b1, vecs[0], 1'b0);
    for (int k = 0; k < K; k++) begin
      runCycle($sformatf("%s.feed%0d", tag, k), P_FEED, 1'b1, vecs[k], k == K - 1);
      if (k == bubbleAfter)
        for (int b = 0; b < bubbles; b++)
          runCycle($sformatf("%s.bubble%0d", tag, b), P_BUBBLE, 1'b0, vecs[0], 1'b1);
    end
    for (int f = 0; f < 2 * (N - 1); f++)
      runCycle($sformatf("%s.flush%0d", tag, f), P_FLUSH, holdValid, vecs[0], 1'b1);
    runCycle({tag, ".done"}, P_DONE, holdValid, vecs[0], 1'b0);
    checkOutput({tag, ".shiftTotal"}, 64'(shiftCount), 64'(K + 2 * (N - 1)));
  endtask

  // Fixed per-advance sequences for the [1..4],[5..8],[9..12] tile at lanes 0 and 3.
  task automatic checkTileLanes(input string tag);
    int exp0 [9] = '{1, 5, 9, 0, 0, 0, 0, 0, 0};
    int exp3 [9] = '{0, 0, 0, 4, 8, 12, 0, 0, 0};
    logic [W-1:0] v;
    checkOutput({tag, ".advCount"}, 64'(advLog.size()), 64'd9);
    for (int n = 0; n < 9 && n < advLog.size(); n++) begin
      v = advLog[n];
      checkOutput($sformatf("%s.lane0[%0d]", tag, n), 64'(v[0 +: DW]),    64'(8'(exp0[n])));
      checkOutput($sformatf("%s.lane3[%0d]", tag, n), 64'(v[3*DW +: DW]), 64'(8'(exp3[n])));
    end
  endtask

  logic [W-1:0] tileVecs [$];
  logic [W-1:0] oneVec [$];
  logic [W-1:0] lv;

  initial begin
    tileVecs.push_back(pack4(1, 2, 3, 4));
    tileVecs.push_back(pack4(5, 6, 7, 8));
    tileVecs.push_back(pack4(9, 10, 11, 12));
    oneVec.push_back(pack4(-128, 127, -1, 0));
    resetModel();
    applyStimulus(1'b1, tileVecs[0], 1'b0);
    rst_n = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.out",    64'(o_out_data),      64'd0);
    checkOutput("rst.ready",  64'(feedIf.in_ready), 64'd0);
    checkOutput("rst.shift",  64'(o_shift_en),      64'd0);
    checkOutput("rst.accEn",  64'(o_acc_en),        64'd0);
    checkOutput("rst.accRst", 64'(o_acc_rst),       64'd0);
    checkOutput("rst.busy",   64'(o_busy),          64'd0);
    checkOutput("rst.done",   64'(o_done),          64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    runTile("t2", tileVecs, -1, 0, 1'b0);
    checkTileLanes("t2");

    runTile("t3", tileVecs, 0, 2, 1'b0);
    checkTileLanes("t3");

    runTile("t4", oneVec, -1, 0, 1'b0);
    checkOutput("t4.advCount", 64'(advLog.size()), 64'd7);
    if (advLog.size() >= 4) begin
      lv = advLog[0]; checkOutput("t4.lane0", 64'(lv[0 +: DW]),    64'h80);
      lv = advLog[1]; checkOutput("t4.lane1", 64'(lv[DW +: DW]),   64'h7F);
      lv = advLog[2]; checkOutput("t4.lane2", 64'(lv[2*DW +: DW]), 64'hFF);
      lv = advLog[3]; checkOutput("t4.lane3", 64'(lv[3*DW +: DW]), 64'h00);
    end

    // Abort a tile with reset during its third flush cycle.
    runCycle("t5.idle",  P_IDLE,  1'b1, tileVecs[0], 1'b0);
    runCycle("t5.clear", P_CLEAR, 1'b1, tileVecs[0], 1'b0);
    for (int k = 0; k < 3; k++)
      runCycle($sformatf("t5.feed%0d", k), P_FEED, 1'b1, tileVecs[k], k == 2);
    for (int f = 0; f < 2; f++)
      runCycle($sformatf("t5.flush%0d", f), P_FLUSH, 1'b0, tileVecs[0], 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5.rst.out",   64'(o_out_data), 64'd0);
    checkOutput("t5.rst.shift", 64'(o_shift_en), 64'd0);
    checkOutput("t5.rst.accEn", 64'(o_acc_en),   64'd0);
    checkOutput("t5.rst.busy",  64'(o_busy),     64'd0);
    checkOutput("t5.rst.done",  64'(o_done),     64'd0);
    resetModel();
    repeat (3) begin
      @(negedge clk);
      checkOutput("t5.rst.noDone", 64'(o_done), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runTile("t5b", tileVecs, -1, 0, 1'b0);
    checkTileLanes("t5b");

    runTile("t6a", tileVecs, -1, 0, 1'b1);
    checkTileLanes("t6a");
    runTile("t6b", tileVecs, -1, 0, 1'b1);
    checkTileLanes("t6b");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
